complex_res_accumulator: RTL and testbench

- Consumer (receiver end) of the complex multiplier result stream: accepts res_val/res_ready/res_data transfers and sums ACC_LEN consecutive complex products into one complex dot-product result.
- Sits downstream of complex_nr_mult_4 and presents the sum on a second valid/ready output stream.
- Honours the same sw_rst software clear as the multiplier.

---
 rtl/complex_mult_pkg.sv | 32 +++
 rtl/complex_acc_lane.sv | 31 +++
 rtl/complex_res_accumulator.sv | 131 +++++++++++++
 tb/tb_complex_res_accumulator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex result accumulator: state encoding,
// accumulator width helper and res_data/acc_data field positions.
package complex_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  function automatic int clog2_min0(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Guard bits let ACC_LEN worst-case products sum without wrapping.
  function automatic int acc_width(input int dw, input int len);
    return 2 * dw + clog2_min0(len);
  endfunction

  function automatic int res_comp_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int res_re_msb(input int dw);
    return 4 * dw - 1;
  endfunction

  function automatic int res_im_msb(input int dw);
    return 2 * dw - 1;
  endfunction

endpackage

// File: rtl/complex_acc_lane.sv
// One signed accumulator lane: sign-extends a product component and adds it
// under enable; a synchronous clear has priority over the add.
module complex_acc_lane #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clear,
  input  logic             i_add_en,
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_acc
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_ext;

  assign w_ext = ACC_W'($signed(i_data));
  assign o_acc = r_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= r_acc + w_ext;
    end
  end

endmodule

// File: rtl/complex_res_accumulator.sv
// Sums ACC_LEN complex products from the multiplier into one dot-product result.
// Optional macro COMPLEX_RES_ACC_STALL_CNT_EN adds a saturating backpressure counter.
module complex_res_accumulator
  import complex_mult_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_LEN    = 4,
  localparam int ACC_W      = acc_width(DATA_WIDTH, ACC_LEN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    res_val,
  output logic                    res_ready,
  input  logic [4*DATA_WIDTH-1:0] res_data,
  output logic                    acc_val,
  input  logic                    acc_ready,
  output logic [2*ACC_W-1:0]      acc_data
`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int COMP_W = res_comp_w(DATA_WIDTH);
  localparam int RE_MSB = res_re_msb(DATA_WIDTH);
  localparam int IM_MSB = res_im_msb(DATA_WIDTH);
  localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  acc_state_t       r_state;
  acc_state_t       w_next_state;
  logic [CNT_W-1:0] r_count;
  logic             w_xfer;
  logic             w_last;
  logic             w_release;
  logic             w_clear;
  logic             w_add;
  logic [COMP_W-1:0] w_res_re;
  logic [COMP_W-1:0] w_res_im;
  logic [ACC_W-1:0]  w_acc_re;
  logic [ACC_W-1:0]  w_acc_im;

  assign w_res_re = res_data[RE_MSB -: COMP_W];
  assign w_res_im = res_data[IM_MSB -: COMP_W];

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign res_ready = (r_state == ACCUM);
  assign acc_val   = (r_state == HOLD);
  assign acc_data  = {w_acc_re, w_acc_im};

  assign w_xfer    = res_val & res_ready;
  assign w_last    = w_xfer && (r_count == LAST_CNT);
  assign w_release = acc_val & acc_ready;
  assign w_clear   = sw_rst | w_release;
  assign w_add     = w_xfer & ~sw_rst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (sw_rst) begin
      w_next_state = ACCUM;
    end else begin
      case (r_state)
        IDLE:    w_next_state = ACCUM;
        ACCUM:   if (w_last) w_next_state = HOLD;
        HOLD:    if (acc_ready) w_next_state = ACCUM;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (sw_rst || w_release || w_last) begin
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + 1'b1;
    end
  end

  complex_acc_lane #(
    .IN_W  (COMP_W),
    .ACC_W (ACC_W)
  ) u_lane_re (
    .clk      (clk),
    .rstn     (rstn),
    .i_clear  (w_clear),
    .i_add_en (w_add),
    .i_data   (w_res_re),
    .o_acc    (w_acc_re)
  );

  complex_acc_lane #(
    .IN_W  (COMP_W),
    .ACC_W (ACC_W)
  ) u_lane_im (
    .clk      (clk),
    .rstn     (rstn),
    .i_clear  (w_clear),
    .i_add_en (w_add),
    .i_data   (w_res_im),
    .o_acc    (w_acc_im)
  );

`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Cumulative across groups; only reset or sw_rst clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (sw_rst) begin
      r_stall_cnt <= '0;
    end else if (acc_val && !acc_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_complex_res_accumulator.sv
// Directed scoreboard bench for complex_res_accumulator (ACC_LEN=4 and ACC_LEN=1 instances).
module tb_complex_res_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        swRst;
  logic        resVal;
  logic        resReady;
  logic [31:0] resData;
  logic        accVal;
  logic        accReady;
  logic [35:0] accData;

  logic        resVal1;
  logic        resReady1;
  logic [31:0] resData1;
  logic        accVal1;
  logic        accReady1;
  logic [31:0] accData1;

`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
  logic [15:0] stallCnt;
  logic [15:0] stallCnt1;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  logic [35:0] expQ[$];
  logic [31:0] expQ1[$];
  int sumRe  = 0;
  int sumIm  = 0;
  int grpCnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  complex_res_accumulator #(
    .DATA_WIDTH (8),
    .ACC_LEN    (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_rst    (swRst),
    .res_val   (resVal),
    .res_ready (resReady),
    .res_data  (resData),
    .acc_val   (accVal),
    .acc_ready (accReady),
    .acc_data  (accData)
`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
    ,
    .stall_cnt (stallCnt)
`endif
  );

  complex_res_accumulator #(
    .DATA_WIDTH (8),
    .ACC_LEN    (1)
  ) dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .sw_rst    (swRst),
    .res_val   (resVal1),
    .res_ready (resReady1),
    .res_data  (resData1),
    .acc_val   (accVal1),
    .acc_ready (accReady1),
    .acc_data  (accData1)
`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
    ,
    .stall_cnt (stallCnt1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one result and returns after the edge on which it was accepted.
  task automatic applyStimulus(input int re, input int im);
    int waited;
    resData = {re[15:0], im[15:0]};
    resVal  = 1'b1;
    waited  = 0;
    while (!resReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("res_ready_wait", 64'(waited < 20), 64'd1);
    @(negedge clk);
    sumRe += re;
    sumIm += im;
    grpCnt++;
    if (grpCnt == 4) begin
      expQ.push_back({18'(sumRe), 18'(sumIm)});
      sumRe  = 0;
      sumIm  = 0;
      grpCnt = 0;
    end
  endtask

  // Waits for acc_val, then pops the scoreboard and compares the sum.
  task automatic checkOutput(input string tag, output int waited);
    logic [35:0] exp;
    waited = 0;
    while (!accVal && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_val"}, 64'(accVal), 64'd1);
    if (expQ.size() == 0) begin
      check({tag, "_queue"}, 64'(expQ.size()), 64'd1);
    end else begin
      exp = expQ.pop_front();
      check({tag, "_data"}, 64'(accData), 64'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    int lastCyc;
    logic [35:0] held;
    logic [31:0] exp1;

    rstn      = 1'b0;
    swRst     = 1'b0;
    resVal    = 1'b0;
    resData   = '0;
    accReady  = 1'b1;
    resVal1   = 1'b0;
    resData1  = '0;
    accReady1 = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_res_ready", 64'(resReady), 64'd0);
    check("reset_acc_val", 64'(accVal), 64'd0);
    check("reset_acc_data", 64'(accData), 64'd0);
`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
    check("reset_stall_cnt", 64'(stallCnt), 64'd0);
`endif
    rstn = 1'b1;
    check("release_idle", 64'(resReady), 64'd0);
    @(negedge clk);
    check("release_accum", 64'(resReady), 64'd1);

    // Group 1: 4 x (100, -50)
    for (int i = 0; i < 4; i++) applyStimulus(100, -50);
    resVal = 1'b0;
    checkOutput("grp1", waited);
    check("grp1_latency", 64'(waited), 64'd0);
    check("grp1_ready_low", 64'(resReady), 64'd0);
    @(negedge clk);
    check("grp1_val_drop", 64'(accVal), 64'd0);
    check("grp1_ready_back", 64'(resReady), 64'd1);

    // Group 2: extreme values, no wrap
    for (int i = 0; i < 4; i++) applyStimulus(-32768, 32767);
    resVal = 1'b0;
    checkOutput("grp2", waited);
    @(negedge clk);

    // Group 3: backpressure for 10 cycles
    accReady = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(3, -7);
    resVal = 1'b0;
    held = expQ[0];
    for (int i = 0; i < 10; i++) begin
      check("hold_val", 64'(accVal), 64'd1);
      check("hold_ready", 64'(resReady), 64'd0);
      check("hold_data", 64'(accData), 64'(held));
      @(negedge clk);
    end
`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
    check("stall_cnt_10", 64'(stallCnt), 64'd10);
`endif
    checkOutput("grp3", waited);
    accReady = 1'b1;
    @(negedge clk);
    check("grp3_val_drop", 64'(accVal), 64'd0);

    // sw_rst while a sum is pending drops it without a handshake
    accReady = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(2, 2);
    resVal = 1'b0;
    check("swhold_val", 64'(accVal), 64'd1);
    swRst = 1'b1;
    @(negedge clk);
    swRst = 1'b0;
    void'(expQ.pop_front());
    check("swhold_val_drop", 64'(accVal), 64'd0);
    check("swhold_ready", 64'(resReady), 64'd1);
    check("swhold_data", 64'(accData), 64'd0);
`ifdef COMPLEX_RES_ACC_STALL_CNT_EN
    check("swhold_stall_clr", 64'(stallCnt), 64'd0);
`endif
    accReady = 1'b1;

    // sw_rst coincident with a third transfer discards it and the partial sum
    applyStimulus(5, 5);
    applyStimulus(5, 5);
    resData = {16'd7, 16'd7};
    resVal  = 1'b1;
    swRst   = 1'b1;
    @(negedge clk);
    swRst  = 1'b0;
    resVal = 1'b0;
    sumRe  = 0;
    sumIm  = 0;
    grpCnt = 0;
    check("swrst_ready", 64'(resReady), 64'd1);
    check("swrst_val", 64'(accVal), 64'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2);
    resVal = 1'b0;
    checkOutput("swrst_grp", waited);
    @(negedge clk);

    // rstn pulsed while in HOLD
    accReady = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(9, 9);
    resVal = 1'b0;
    check("rst_hold_val", 64'(accVal), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_val", 64'(accVal), 64'd0);
    check("rst_async_ready", 64'(resReady), 64'd0);
    check("rst_async_data", 64'(accData), 64'd0);
    void'(expQ.pop_front());
    @(negedge clk);
    rstn     = 1'b1;
    accReady = 1'b1;
    check("rst_rel_idle", 64'(resReady), 64'd0);
    @(negedge clk);
    check("rst_rel_accum", 64'(resReady), 64'd1);

    // ACC_LEN=1 pass-through: one output per two cycles
    lastCyc = 0;
    for (int i = 1; i <= 6; i++) begin
      resData1 = {16'(i), 16'(-i)};
      resVal1  = 1'b1;
      expQ1.push_back({16'(i), 16'(-i)});
      waited = 0;
      while (!resReady1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("p1_ready_wait", 64'(waited < 20), 64'd1);
      if (i > 1) check("p1_interval", 64'(cyc - lastCyc), 64'd2);
      lastCyc = cyc;
      @(negedge clk);
      check("p1_val", 64'(accVal1), 64'd1);
      exp1 = expQ1.pop_front();
      check("p1_data", 64'(accData1), 64'(exp1));
    end
    resVal1 = 1'b0;
    @(negedge clk);
    check("p1_idle_val", 64'(accVal1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
